// File: rtl/fault_campaign_controller_pkg.sv
// Shared types and constants for the fault campaign controller and its LFSR.
package fault_campaign_controller_pkg;

    localparam int unsigned LFSR_W      = 16;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [2:0]  VOTER_AGREE = 3'b000;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_SINGLE   = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_RANDOM   = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_INJECT   = 3'd2,
        ST_WAIT_DET = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef struct packed {
        mode_t      mode;
        logic [2:0] mask;
        logic [7:0] num_faults;
    } campaign_cfg_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

    // One-hot core choice: start at sel (3 folds to A), walk A->B->C to the first masked core.
    function automatic logic [2:0] pick_core(input logic [1:0] sel, input logic [2:0] mask);
        logic [2:0] onehot;
        logic       found;
        logic [1:0] first;
        logic [1:0] idx;
        onehot = 3'b000;
        found  = 1'b0;
        first  = (sel == 2'd3) ? 2'd0 : sel;
        for (int unsigned i = 0; i < 3; i++) begin
            idx = 2'((32'(first) + i) % 3);
            if (!found && mask[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/fault_campaign_controller_lfsr16.sv
// 16-bit Galois LFSR; free-running outside reset, a zero seed is forced to 1.
module lfsr16
    import fault_campaign_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst_in,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] seed_eff;

    assign seed_eff = (seed == '0) ? LFSR_W'(1) : seed;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            q <= seed_eff;
        end else begin
            q <= {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/fault_campaign_controller.sv
// Runs single-shot, periodic or random error-injection campaigns on the TMR cores
// and tallies voter detections against the injections.
module fault_campaign_controller
    import fault_campaign_controller_pkg::*;
#(
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int unsigned DETECT_TIMEOUT = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [2:0]       core_mask,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] period,
    input  logic [7:0]       num_faults,
    input  logic             core_hold,
    input  logic [2:0]       Voter_state,
    output logic             Core_A_inject_error,
    output logic             Core_B_inject_error,
    output logic             Core_C_inject_error,
    output logic             busy,
    output logic             done,
    output logic [7:0]       faults_injected,
    output logic [7:0]       faults_detected,
    output logic             missed_detect
);

    localparam int unsigned T_W = (DETECT_TIMEOUT > 1) ? $clog2(DETECT_TIMEOUT) : 1;

    state_t            state;
    state_t            state_d;
    campaign_cfg_t     cfg;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  gap_load;
    logic [T_W-1:0]    tcnt;
    logic [LFSR_W-1:0] lfsr;
    logic [2:0]        strobe;
    logic              accept;
    logic              voter_hit;
    logic              wait_exit;
    logic              campaign_end;

    lfsr16 u_lfsr (
        .clk    (clk),
        .rst_in (rst_in),
        .seed   (SEED),
        .q      (lfsr)
    );

    assign accept       = start && (mode != MODE_OFF) && (core_mask != 3'b000) &&
                          ((mode == MODE_SINGLE) || (num_faults != 8'd0));
    assign voter_hit    = (Voter_state != VOTER_AGREE);
    assign wait_exit    = voter_hit || (tcnt == '0);
    assign campaign_end = (cfg.mode == MODE_SINGLE) || (faults_injected == cfg.num_faults);
    assign gap_load     = (cfg.mode == MODE_RANDOM) ? (CNT_W'(lfsr) & period_q)
                                                    : (period_q - CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decision; the zero-cycle NEXT step is folded into WAIT_DET's exit
    always_comb begin
        state_d = state;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (accept) state_d = ST_DELAY;
                ST_DELAY:         if (!core_hold && cnt == '0) state_d = ST_INJECT;
                ST_INJECT:        if (!core_hold) state_d = ST_WAIT_DET;
                ST_WAIT_DET:      if (!core_hold && wait_exit)
                                      state_d = campaign_end ? ST_DONE : ST_GAP;
                ST_GAP:           if (!core_hold && cnt == '0) state_d = ST_INJECT;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Campaign config, timers and status counters
    always_ff @(posedge clk) begin
        if (rst_in) begin
            cfg             <= '0;
            period_q        <= '0;
            cnt             <= '0;
            tcnt            <= '0;
            faults_injected <= '0;
            faults_detected <= '0;
            missed_detect   <= 1'b0;
        end else if (!stop) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        cfg.mode        <= mode_t'(mode);
                        cfg.mask        <= core_mask;
                        cfg.num_faults  <= num_faults;
                        period_q        <= period;
                        cnt             <= delay;
                        faults_injected <= '0;
                        faults_detected <= '0;
                        missed_detect   <= 1'b0;
                    end
                end
                ST_DELAY, ST_GAP: begin
                    if (!core_hold && cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                ST_INJECT: begin
                    if (!core_hold) begin
                        tcnt            <= T_W'(DETECT_TIMEOUT - 1);
                        faults_injected <= sat_inc8(faults_injected);
                    end
                end
                ST_WAIT_DET: begin
                    if (!core_hold) begin
                        if (voter_hit) begin
                            faults_detected <= sat_inc8(faults_detected);
                            cnt             <= gap_load;
                        end else if (tcnt == '0) begin
                            missed_detect <= 1'b1;
                            cnt           <= gap_load;
                        end else begin
                            tcnt <= tcnt - T_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are only live in an unheld, unaborted INJECT cycle
    always_comb begin
        strobe = 3'b000;
        if (state == ST_INJECT && !core_hold && !stop && !rst_in) begin
            strobe = (cfg.mode == MODE_RANDOM) ? pick_core(lfsr[1:0], cfg.mask) : cfg.mask;
        end
        Core_A_inject_error = strobe[0];
        Core_B_inject_error = strobe[1];
        Core_C_inject_error = strobe[2];
        busy = (state != ST_IDLE) && (state != ST_DONE);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_fault_campaign_controller.sv
// Directed bench for fault_campaign_controller: a campaign vector table plus
// hand-written hold, stop, reset, ignored-start and random-mode sequences.
module tb_fault_campaign_controller;

    logic        clk;
    logic        rst_in;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [2:0]  core_mask;
    logic [15:0] delay;
    logic [15:0] period;
    logic [7:0]  num_faults;
    logic        core_hold;
    logic [2:0]  Voter_state;
    logic        Core_A_inject_error;
    logic        Core_B_inject_error;
    logic        Core_C_inject_error;
    logic        busy;
    logic        done;
    logic [7:0]  faults_injected;
    logic [7:0]  faults_detected;
    logic        missed_detect;
    logic [2:0]  strobes;
    logic [15:0] lfsr_m;

    int tests;
    int failed;

    fault_campaign_controller #(
        .SEED           (16'hACE1),
        .DETECT_TIMEOUT (8),
        .CNT_W          (16)
    ) dut (
        .clk                 (clk),
        .rst_in              (rst_in),
        .start               (start),
        .stop                (stop),
        .mode                (mode),
        .core_mask           (core_mask),
        .delay               (delay),
        .period              (period),
        .num_faults          (num_faults),
        .core_hold           (core_hold),
        .Voter_state         (Voter_state),
        .Core_A_inject_error (Core_A_inject_error),
        .Core_B_inject_error (Core_B_inject_error),
        .Core_C_inject_error (Core_C_inject_error),
        .busy                (busy),
        .done                (done),
        .faults_injected     (faults_injected),
        .faults_detected     (faults_detected),
        .missed_detect       (missed_detect)
    );

    assign strobes = {Core_C_inject_error, Core_B_inject_error, Core_A_inject_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Galois LFSR, taps B400, seeded on reset
    always @(posedge clk) begin
        if (rst_in) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  mask;
        logic [15:0] delay;
        logic [15:0] period;
        logic [7:0]  num;
        int          lag;
        int          hold_lo;
        int          hold_hi;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_c;
        logic [7:0]  exp_inj;
        logic [7:0]  exp_det;
        logic        exp_missed;
        int          exp_done;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_core(input logic [15:0] l, input logic [2:0] m);
        int s;
        s = (l[1:0] == 2'd3) ? 0 : int'(l[1:0]);
        for (int k = 0; k < 3; k++) begin
            if (m[(s + k) % 3]) return 3'b001 << ((s + k) % 3);
        end
        return 3'b000;
    endfunction

    task automatic launch(input logic [1:0] md, input logic [2:0] mk, input logic [15:0] dl,
                          input logic [15:0] pr, input logic [7:0] nf);
        mode = md; core_mask = mk; delay = dl; period = pr; num_faults = nf;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] got_a, got_b, got_c;
        int done_at, vcyc, n, b_seen;

        tests = 0; failed = 0;
        rst_in = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; core_mask = 3'b000;
        delay = '0; period = '0; num_faults = '0; core_hold = 1'b0; Voter_state = 3'b000;

        //            mode  mask    dly    per    num  lag hlo hhi  exp_a       exp_b       exp_c      inj det mis done
        vecs[0] = '{2'd1, 3'b010, 16'd5, 16'd0, 8'd0,  2, -1, -1, 32'h0,      32'h40,     32'h0,     8'd1, 8'd1, 1'b0,  9};
        vecs[1] = '{2'd2, 3'b001, 16'd0, 16'd4, 8'd3,  1, -1, -1, 32'h2082,   32'h0,      32'h0,     8'd3, 8'd3, 1'b0, 15};
        vecs[2] = '{2'd1, 3'b100, 16'd3, 16'd0, 8'd0,  1,  2,  5, 32'h0,      32'h0,      32'h100,   8'd1, 8'd1, 1'b0, 10};
        vecs[3] = '{2'd1, 3'b001, 16'd0, 16'd0, 8'd0, -1, -1, -1, 32'h2,      32'h0,      32'h0,     8'd1, 8'd0, 1'b1, 10};
        vecs[4] = '{2'd2, 3'b011, 16'd2, 16'd1, 8'd2,  1, -1, -1, 32'h48,     32'h48,     32'h0,     8'd2, 8'd2, 1'b0,  8};
        vecs[5] = '{2'd1, 3'b001, 16'd1, 16'd0, 8'd0,  0, -1, -1, 32'h4,      32'h0,      32'h0,     8'd1, 8'd0, 1'b1, 11};
        vecs[6] = '{2'd2, 3'b100, 16'd0, 16'd3, 8'd1,  3, -1, -1, 32'h0,      32'h0,      32'h2,     8'd1, 8'd1, 1'b0,  5};

        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        check("reset outputs", {22'd0, strobes, busy, done, faults_injected, faults_detected, missed_detect}, 32'd0);

        // Campaign table; cycle 0 is the cycle right after the accepting edge
        for (int v = 0; v < NV; v++) begin
            launch(vecs[v].mode, vecs[v].mask, vecs[v].delay, vecs[v].period, vecs[v].num);
            got_a = '0; got_b = '0; got_c = '0; done_at = -1; vcyc = -1;
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                if (c == 0) check($sformatf("v%0d busy", v), 32'(busy), 32'd1);
                got_a[c] = Core_A_inject_error;
                got_b[c] = Core_B_inject_error;
                got_c[c] = Core_C_inject_error;
                if (strobes != 3'b000 && vecs[v].lag >= 0) vcyc = c + vecs[v].lag;
                if (done && done_at < 0) done_at = c;
                Voter_state = (c == vcyc) ? 3'b010 : 3'b000;
                core_hold   = (c >= vecs[v].hold_lo) && (c <= vecs[v].hold_hi);
            end
            Voter_state = 3'b000; core_hold = 1'b0;
            check($sformatf("v%0d strobe_a", v), got_a, vecs[v].exp_a);
            check($sformatf("v%0d strobe_b", v), got_b, vecs[v].exp_b);
            check($sformatf("v%0d strobe_c", v), got_c, vecs[v].exp_c);
            check($sformatf("v%0d done_cycle", v), 32'(done_at), 32'(vecs[v].exp_done));
            check($sformatf("v%0d injected", v), 32'(faults_injected), 32'(vecs[v].exp_inj));
            check($sformatf("v%0d detected", v), 32'(faults_detected), 32'(vecs[v].exp_det));
            check($sformatf("v%0d missed", v), 32'(missed_detect), 32'(vecs[v].exp_missed));
        end

        // core_hold raised inside INJECT delays the strobe to the first unheld cycle
        launch(2'd1, 3'b010, 16'd0, 16'd0, 8'd0);
        @(posedge clk);
        #1 core_hold = 1'b1;
        @(negedge clk);
        check("hold inject strobe", 32'(strobes), 32'd0);
        @(posedge clk);
        #1 core_hold = 1'b0;
        @(negedge clk);
        check("hold release strobe", 32'(strobes), 32'b010);
        check("hold release injected", 32'(faults_injected), 32'd0);
        @(negedge clk);
        check("hold after inject", {24'd0, strobes, 4'd0, faults_injected[0]}, 32'd1);
        wait_done("hold done", 20);
        check("hold missed", 32'(missed_detect), 32'd1);

        // stop during a long delay aborts with no strobe
        launch(2'd1, 3'b001, 16'd10, 16'd0, 8'd0);
        repeat (4) @(negedge clk);
        check("stop busy before", 32'(busy), 32'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop busy after", {30'd0, busy, done}, 32'd0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (strobes != 3'b000) n++;
        end
        check("stop no strobe", 32'(n), 32'd0);

        // starts that must be ignored
        launch(2'd1, 3'b000, 16'd0, 16'd0, 8'd1);
        @(negedge clk);
        check("ignore mask0", 32'(busy), 32'd0);
        launch(2'd0, 3'b001, 16'd0, 16'd0, 8'd1);
        @(negedge clk);
        check("ignore mode0", 32'(busy), 32'd0);
        launch(2'd2, 3'b001, 16'd0, 16'd4, 8'd0);
        @(negedge clk);
        check("ignore num0", 32'(busy), 32'd0);

        // reset while in GAP
        launch(2'd2, 3'b001, 16'd0, 16'd10, 8'd3);
        repeat (12) @(negedge clk);
        check("gap state", {29'd0, busy, faults_injected[0], missed_detect}, 32'b111);
        rst_in = 1'b1;
        @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        check("gap reset outputs", {22'd0, strobes, busy, done, faults_injected, faults_detected, missed_detect}, 32'd0);
        check("gap reset lfsr", 32'(dut.u_lfsr.q), 32'hACE1);

        // random mode: one masked core per strobe, chosen from the LFSR
        launch(2'd3, 3'b101, 16'd0, 16'd7, 8'd32);
        n = 0; b_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (strobes != 3'b000) begin
                n++;
                if (Core_B_inject_error) b_seen++;
                check($sformatf("rand strobe %0d", n), 32'(strobes), 32'(exp_core(lfsr_m, 3'b101)));
            end
            if (done) break;
        end
        check("rand done", 32'(done), 32'd1);
        check("rand count", 32'(n), 32'd32);
        check("rand no B", 32'(b_seen), 32'd0);
        check("rand injected", 32'(faults_injected), 32'd32);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fault_campaign_controller.md
Name: fault_campaign_controller

Overview:
Drives the per-core error-injection strobes Core_A/B/C_inject_error into the TMR core array, which are currently tied to 0. Runs programmable fault campaigns: single-shot, periodic or pseudo-random, over a selected set of cores. Observes Voter_state to count detected faults and flag missed detections. Sits beside Rst_Controller in the top level and feeds the three Main_core inject inputs.

Parameters:
SEED, 16'hACE1, initial LFSR value; a value of 0 is replaced by 16'h0001.
DETECT_TIMEOUT, 16, cycles to wait for a nonzero Voter_state after each injection.
CNT_W, 16, width of the delay and period counters.

Ports:
clk  in  1  system clock
rst_in  in  1  reset; one clock; synchronous, active-high
start  in  1  one-cycle pulse; launches a campaign from IDLE or DONE
stop  in  1  abort; returns to IDLE next cycle
mode  in  2  0 off, 1 single-shot, 2 periodic, 3 random
core_mask  in  3  bit0 = A, bit1 = B, bit2 = C
delay  in  CNT_W  cycles between start and the first injection
period  in  CNT_W  gap for mode 2; gap mask for mode 3
num_faults  in  8  injections per campaign (modes 2 and 3)
core_hold  in  1  recovery in progress; freezes the campaign
Voter_state  in  3  voter result; 3'b000 = all agree, nonzero = disagreement
Core_A_inject_error  out  1  one-cycle strobe to core A
Core_B_inject_error  out  1  one-cycle strobe to core B
Core_C_inject_error  out  1  one-cycle strobe to core C
busy  out  1  high in any state other than IDLE and DONE
done  out  1  high in DONE
faults_injected  out  8  injection count, saturating
faults_detected  out  8  detection count, saturating
missed_detect  out  1  sticky; set when any detection times out

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; LFSR = SEED.
  - Reset wins over all other inputs.
  - Reset mid-campaign aborts immediately; no strobe is emitted in the reset cycle.
- Launch: start is accepted in IDLE or DONE only when mode != 0, core_mask != 0 and (mode == 1 or num_faults != 0). Otherwise start is ignored.
  - On accept: latch mode, mask, delay, period and num_faults; clear the three status counters; go to DELAY with cnt = delay.
- stop has priority over start and over every transition. It goes to IDLE next cycle, strobes 0, counters retained.
- FSM:
  - DELAY: if cnt == 0, go to INJECT; else cnt--.
  - INJECT: strobe(s) high for exactly this cycle, then go to WAIT_DET with tcnt = DETECT_TIMEOUT-1. faults_injected++.
  - WAIT_DET: if Voter_state != 0, faults_detected++ and go to NEXT. Else if tcnt == 0, set missed_detect and go to NEXT. Else tcnt--.
  - NEXT (0 cycles, decision only): if mode == 1 or faults_injected == latched num_faults, go to DONE. Else go to GAP with cnt = period-1 (mode 2) or cnt = (lfsr & period) (mode 3).
  - GAP: if cnt == 0, go to INJECT; else cnt--.
  - DONE: done = 1, held until start or stop.
- Latency: start accepted at edge t, delay = D → strobe asserted in cycle t+1+D. delay = 0 gives the strobe in the cycle after start.
- core_hold = 1 freezes state, cnt and tcnt. In INJECT it suppresses the strobe until the cycle core_hold = 0. The LFSR keeps running.
- Core selection:
  - Modes 1 and 2: every masked core is strobed together, which allows double-fault tests.
  - Mode 3: exactly one core. Index = lfsr[1:0], with 3 mapped to 0. If that core is unmasked, step A→B→C→A to the first masked core.
- LFSR: 16-bit Galois, taps 16'hB400, shifts every cycle outside reset.
- Counters saturate at 255. A Voter_state pulse outside WAIT_DET is ignored.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, DELAY, INJECT, WAIT_DET, GAP, DONE)
  - mode codes
  - LFSR tap constant
  - the Voter_state "agree" code 3'b000
- One sub-module, lfsr16 (clk, rst_in, seed, q), reused later for memory scrubbing tests.

Test Plan:
1. mode=1, mask=010, delay=5, start at t=0; Voter_state=3'b010 in cycle 8 → Core_B strobe only, in cycle 6 only; faults_detected=1; done=1 from cycle 9; missed_detect=0.
2. mode=2, mask=001, num=3, period=4, delay=0; Voter_state nonzero 1 cycle after each strobe → A strobes in cycles 1, 7, 13; injected=3; detected=3; done from cycle 15.
3. mode=1, mask=100, delay=3, start t=0, core_hold=1 in cycles 2–5 → C strobe in cycle 8, not 4.
4. mode=1, mask=001, Voter_state held 0, DETECT_TIMEOUT=8 → missed_detect=1 and detected=0 after 8 wait cycles; done asserts.
5. stop in cycle 3 of a delay=10 campaign → busy=0 next cycle, no strobe ever. Separately, rst_in asserted during GAP → all outputs 0 the next cycle, LFSR=SEED.
6. mode=3, mask=101, num=32, period=7, default SEED → 32 strobes total, each on exactly one core, none on B; start with mask=000 → ignored, busy stays 0.
